// File: rtl/sys_ctrl_pkg.sv
// Shared constants and state types for the UART command controller.
// Imported by the RTL and the bench so opcode values live in one place.
package sys_ctrl_pkg;

    localparam logic [7:0] CMD_WR   = 8'hAA;
    localparam logic [7:0] CMD_RD   = 8'hBB;
    localparam logic [7:0] ACK_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_RD_ADDR,
        ST_RD_WAIT,
        ST_TX_SEND,
        ST_TX_WAIT
    } ctrl_state_t;

    typedef enum logic [1:0] {
        LS_IDLE,
        LS_SEND,
        LS_WAIT
    } launch_state_t;

endpackage

// File: rtl/tx_launch.sv
// Launches one byte into the UART transmitter via its data_valid/busy handshake.
// Latency: tx_data_valid in the cycle after req when tx_busy is low, else the cycle after busy falls.
// Backpressure: holds the byte while tx_busy is high; done fires once busy is seen high after launch.
module tx_launch
    import sys_ctrl_pkg::*;
#(
    parameter int dataWidth = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req,
    input  logic [dataWidth-1:0] req_data,
    input  logic                 tx_busy,
    output logic [dataWidth-1:0] tx_p_data,
    output logic                 tx_data_valid,
    output logic                 done
);

    launch_state_t lst;

    // The transmitter acknowledges by raising busy; until then a relaunch is unsafe.
    assign done = (lst == LS_WAIT) && tx_busy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lst           <= LS_IDLE;
            tx_p_data     <= '0;
            tx_data_valid <= 1'b0;
        end else begin
            tx_data_valid <= 1'b0;
            case (lst)
                LS_IDLE: begin
                    if (req) begin
                        tx_p_data <= req_data;
                        if (!tx_busy) begin
                            tx_data_valid <= 1'b1;
                            lst           <= LS_WAIT;
                        end else begin
                            lst <= LS_SEND;
                        end
                    end
                end
                LS_SEND: begin
                    if (!tx_busy) begin
                        tx_data_valid <= 1'b1;
                        lst           <= LS_WAIT;
                    end
                end
                LS_WAIT: begin
                    if (tx_busy) begin
                        lst <= LS_IDLE;
                    end
                end
                default: lst <= LS_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_sys_ctrl.sv
// Parses UART byte commands (0xAA wr, 0xBB rd) into single-cycle register-file strobes.
// Latency: strobes one cycle after the final frame byte; read data launched one cycle after rf_rd_valid.
// Backpressure: none on rx (bytes arriving mid-transaction are dropped with cmd_error); tx waits on tx_busy.
// UART_SYS_CTRL_WR_ACK_EN: when defined, every completed write answers with ACK_BYTE.
module uart_sys_ctrl
    import sys_ctrl_pkg::*;
#(
    parameter int dataWidth = 8,
    parameter int addrWidth = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [dataWidth-1:0] rx_p_data,
    input  logic                 rx_data_valid,
    input  logic                 tx_busy,
    output logic [dataWidth-1:0] tx_p_data,
    output logic                 tx_data_valid,
    output logic [addrWidth-1:0] rf_addr,
    output logic [dataWidth-1:0] rf_wr_data,
    output logic                 rf_wr_en,
    output logic                 rf_rd_en,
    input  logic [dataWidth-1:0] rf_rd_data,
    input  logic                 rf_rd_valid,
    output logic                 cmd_error
);

    ctrl_state_t          state;
    logic                 launch_req;
    logic [dataWidth-1:0] launch_dat;
    logic                 launch_done;

    always_comb begin
        launch_req = 1'b0;
        launch_dat = rf_rd_data;
        if (state == ST_RD_WAIT && rf_rd_valid) begin
            launch_req = 1'b1;
        end
`ifdef UART_SYS_CTRL_WR_ACK_EN
        if (state == ST_WR_DATA && rx_data_valid) begin
            launch_req = 1'b1;
            launch_dat = dataWidth'(ACK_BYTE);
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            rf_addr    <= '0;
            rf_wr_data <= '0;
            rf_wr_en   <= 1'b0;
            rf_rd_en   <= 1'b0;
            cmd_error  <= 1'b0;
        end else begin
            rf_wr_en  <= 1'b0;
            rf_rd_en  <= 1'b0;
            cmd_error <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rx_data_valid) begin
                        if (rx_p_data == dataWidth'(CMD_WR)) begin
                            state <= ST_WR_ADDR;
                        end else if (rx_p_data == dataWidth'(CMD_RD)) begin
                            state <= ST_RD_ADDR;
                        end else begin
                            cmd_error <= 1'b1;
                        end
                    end
                end
                ST_WR_ADDR: begin
                    if (rx_data_valid) begin
                        rf_addr <= rx_p_data[addrWidth-1:0];
                        state   <= ST_WR_DATA;
                    end
                end
                ST_WR_DATA: begin
                    if (rx_data_valid) begin
                        rf_wr_data <= rx_p_data;
                        rf_wr_en   <= 1'b1;
`ifdef UART_SYS_CTRL_WR_ACK_EN
                        state      <= ST_TX_SEND;
`else
                        state      <= ST_IDLE;
`endif
                    end
                end
                ST_RD_ADDR: begin
                    if (rx_data_valid) begin
                        rf_addr  <= rx_p_data[addrWidth-1:0];
                        rf_rd_en <= 1'b1;
                        state    <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (rx_data_valid) begin
                        cmd_error <= 1'b1;
                    end
                    if (rf_rd_valid) begin
                        state <= ST_TX_SEND;
                    end
                end
                ST_TX_SEND, ST_TX_WAIT: begin
                    if (rx_data_valid) begin
                        cmd_error <= 1'b1;
                    end
                    // Busy may rise during the launch pulse itself, skipping TX_WAIT.
                    if (launch_done) begin
                        state <= ST_IDLE;
                    end else if (state == ST_TX_SEND && tx_data_valid) begin
                        state <= ST_TX_WAIT;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    tx_launch #(
        .dataWidth(dataWidth)
    ) u_tx_launch (
        .clk          (clk),
        .rst          (rst),
        .req          (launch_req),
        .req_data     (launch_dat),
        .tx_busy      (tx_busy),
        .tx_p_data    (tx_p_data),
        .tx_data_valid(tx_data_valid),
        .done         (launch_done)
    );

endmodule

// File: doc/uart_sys_ctrl.md
# uart_sys_ctrl

Command controller placed between the UART receive/transmit pair and the system register file. Parses byte-framed commands delivered by the UART receiver and issues single-cycle register-file write/read strobes. Returns read data (and optionally write acknowledges) through the UART transmitter using its `data_valid`/`busy` handshake. Everything runs in one clock domain; UART outputs are already synchronous to `clk`.

## Interface
- `dataWidth`, 8, UART byte width; also the register-file data width.
- `addrWidth`, 4, register-file address width; taken from the low bits of the address byte (`addrWidth` ≤ `dataWidth`).
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `rx_p_data`  in  dataWidth  received byte; valid only with `rx_data_valid`.
- `rx_data_valid`  in  1  one-cycle pulse per received byte.
- `tx_busy`  in  1  transmitter busy.
- `tx_p_data`  out  dataWidth  byte to transmit; held stable from the `tx_data_valid` pulse until `tx_busy` is seen high.
- `tx_data_valid`  out  1  one-cycle transmit request.
- `rf_addr`  out  addrWidth  register-file address.
- `rf_wr_data`  out  dataWidth  write data.
- `rf_wr_en`  out  1  one-cycle write strobe.
- `rf_rd_en`  out  1  one-cycle read strobe.
- `rf_rd_data`  in  dataWidth  read data; valid with `rf_rd_valid`.
- `rf_rd_valid`  in  1  read-data-valid pulse.
- `cmd_error`  out  1  one-cycle pulse on an unknown opcode or a dropped byte.

## Operation
- Opcodes:
  - `CMD_WR` = 0xAA: frame is opcode, address, data.
  - `CMD_RD` = 0xBB: frame is opcode, address; the response is one byte of read data.
- FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND, TX_WAIT.
- IDLE, on a byte:
  - 0xAA → WR_ADDR.
  - 0xBB → RD_ADDR.
  - Any other value → stay in IDLE and pulse `cmd_error`.
- WR_ADDR, on a byte: latch `rf_addr` = byte[addrWidth-1:0] → WR_DATA.
- WR_DATA, on a byte:
  - Drive `rf_wr_data` = byte and pulse `rf_wr_en` for exactly one cycle.
  - Then → IDLE, or → TX_SEND with `ACK_BYTE` when the ack option is compiled in.
- RD_ADDR, on a byte: latch `rf_addr`, pulse `rf_rd_en` for one cycle → RD_WAIT.
- RD_WAIT: on `rf_rd_valid`, latch `rf_rd_data` into `tx_p_data` → TX_SEND.
- TX_SEND: when `tx_busy`=0, pulse `tx_data_valid` for one cycle → TX_WAIT. While `tx_busy`=1, keep waiting with no pulse.
- TX_WAIT: stay until `tx_busy`=1 is sampled → IDLE. This prevents a double launch.
- A byte arriving in RD_WAIT, TX_SEND or TX_WAIT is dropped and `cmd_error` pulses; the state is unchanged.
- `rf_addr`, `rf_wr_data` and `tx_p_data` hold their last values between operations.
- Never assert `rf_wr_en` and `rf_rd_en` in the same cycle.

## Timing
- Reset values: every output 0; state IDLE; address and data latches 0.
- Reset asserted mid-frame or mid-transmit aborts immediately. After release the FSM is in IDLE and the partial frame is discarded.
- Write latency: `rf_wr_en` is high in the cycle after the clock edge that samples the data byte's `rx_data_valid`.
- Read latency: `rf_rd_en` is high in the cycle after the address byte is sampled.
- Transmit latency: `tx_data_valid` is high in the cycle after `rf_rd_valid` is sampled, provided `tx_busy`=0.
- `rf_rd_valid` outside RD_WAIT is ignored.
- `tx_busy` is not inspected outside TX_SEND/TX_WAIT.
- Simultaneous events: `rx_data_valid` in the same cycle that the FSM leaves RD_WAIT → that byte is dropped with `cmd_error`.
- Address-byte bits above `addrWidth` are ignored; no range error is raised.

## Configuration
- `UART_SYS_CTRL_WR_ACK_EN` defined: every completed write sends `ACK_BYTE` (0xA5) over TX through TX_SEND/TX_WAIT, with the same handshake as a read response.
- Not defined: writes return straight to IDLE and no TX traffic results from writes.

## Structure
- Shared package `sys_ctrl_pkg` holds:
  - the FSM state typedef;
  - `CMD_WR`, `CMD_RD` and `ACK_BYTE`.
  This lets the testbench and the system top share the constants.
- Natural sub-module: `tx_launch`, a small handshake unit for TX_SEND/TX_WAIT. It takes a request plus byte, waits for `tx_busy` low, pulses `tx_data_valid`, and reports done once `tx_busy` is sampled high. The command FSM stays in the top module.

## Test plan
- Write 0xAA, 0x03, 0x5C → one `rf_wr_en` pulse with `rf_addr`=3 and `rf_wr_data`=0x5C; no TX activity. With `UART_SYS_CTRL_WR_ACK_EN`, exactly one 0xA5 is transmitted.
- Read 0xBB, 0x07; register file returns 0x3E two cycles after `rf_rd_en` → one `tx_data_valid` with `tx_p_data`=0x3E; the FSM stays in TX_WAIT until `tx_busy` rises, then returns to IDLE.
- Read with `tx_busy` held high for 20 cycles when the data returns → `tx_data_valid` is held off until the cycle after `tx_busy` falls, then pulses exactly once.
- Opcode 0x12, then 0xAA, 0x01, 0xFF → one `cmd_error` pulse for 0x12; the following write completes normally at address 1 with data 0xFF.
- Byte 0x55 injected during RD_WAIT → `cmd_error` pulses, the read still completes with the correct data, and the FSM returns to IDLE.
- `rst` asserted after 0xAA, 0x02 and released → all outputs 0; the next 0xBB, 0x02 is treated as a fresh read with no spurious write.
